// File: rtl/bsg_adder_multicycle.sv
// bsg_adder_multicycle: adds two width_p-bit operands plus carry-in over
// width_p/chunk_p cycles, chunk_p bits per cycle starting at the LSB.
// Operands arrive on a valid/ready handshake and the result leaves on a
// valid/yumi handshake. Only one operation is in flight at a time.
// Optional feature macro: BSG_ADDER_MULTICYCLE_OVERFLOW_EN adds overflow_o
// (signed overflow of the full-width sum).
module bsg_adder_multicycle #(
  parameter int width_p = 16,
  parameter int chunk_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic               c_i,
  output logic               v_o,
  output logic [width_p-1:0] s_o,
  output logic               c_o,
  input  logic               yumi_i
`ifdef BSG_ADDER_MULTICYCLE_OVERFLOW_EN
  ,
  output logic               overflow_o
`endif
);

  localparam int N  = width_p / chunk_p;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic [width_p-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic               carry_q, carry_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [chunk_p-1:0] chunk_sum;
  logic               chunk_cout;
  logic [width_p-1:0] s_shift;

  // One chunk_p-bit adder: the only arithmetic on the critical path.
  always_comb begin
    {chunk_cout, chunk_sum} = {1'b0, a_q[chunk_p-1:0]}
                            + {1'b0, b_q[chunk_p-1:0]}
                            + {{chunk_p{1'b0}}, carry_q};
  end

  // New chunk enters the sum register at the MSB end; after N steps the
  // first chunk has walked down to bit 0.
  if (chunk_p == width_p) begin : g_single
    assign s_shift = chunk_sum;
  end else begin : g_multi
    assign s_shift = {chunk_sum, s_q[width_p-1:chunk_p]};
  end

`ifdef BSG_ADDER_MULTICYCLE_OVERFLOW_EN
  logic ovf_q, ovf_d;
`endif

  // Next-state and datapath update for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef BSG_ADDER_MULTICYCLE_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (v_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = c_i;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        s_d     = s_shift;
        a_d     = a_q >> chunk_p;
        b_d     = b_q >> chunk_p;
        carry_d = chunk_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
`ifdef BSG_ADDER_MULTICYCLE_OVERFLOW_EN
          // Top chunk holds the operand MSBs in its top bit.
          ovf_d = (a_q[chunk_p-1] == b_q[chunk_p-1])
               && (chunk_sum[chunk_p-1] != a_q[chunk_p-1]);
`endif
        end
      end
      DONE: begin
        if (yumi_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BSG_ADDER_MULTICYCLE_OVERFLOW_EN
  // Overflow flag, captured on the last BUSY edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ovf_q <= 1'b0;
    else            ovf_q <= ovf_d;
  end
  assign overflow_o = ovf_q;
`endif

  // All outputs come straight from registers.
  assign ready_o = (state_q == IDLE);
  assign v_o     = (state_q == DONE);
  assign s_o     = s_q;
  assign c_o     = carry_q;

endmodule

// File: tb/tb_bsg_adder_multicycle.sv
// Bench for bsg_adder_multicycle: three instances (chunk 4, 16, 1) share
// stimulus; results compared against a plain-arithmetic reference.
module tb_bsg_adder_multicycle;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        v_i, c_i, yumi_i;
  logic [15:0] a_i, b_i;

  logic        rdy4, vo4, c4, rdy16, vo16, c16, rdy1, vo1, c1;
  logic [15:0] s4, s16, s1;
`ifdef BSG_ADDER_MULTICYCLE_OVERFLOW_EN
  logic        ov4, ov16, ov1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsg_adder_multicycle #(.width_p(16), .chunk_p(4)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .ready_o(rdy4),
    .a_i(a_i), .b_i(b_i), .c_i(c_i), .v_o(vo4), .s_o(s4), .c_o(c4),
    .yumi_i(yumi_i)
`ifdef BSG_ADDER_MULTICYCLE_OVERFLOW_EN
    , .overflow_o(ov4)
`endif
  );

  bsg_adder_multicycle #(.width_p(16), .chunk_p(16)) dut16 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .ready_o(rdy16),
    .a_i(a_i), .b_i(b_i), .c_i(c_i), .v_o(vo16), .s_o(s16), .c_o(c16),
    .yumi_i(yumi_i)
`ifdef BSG_ADDER_MULTICYCLE_OVERFLOW_EN
    , .overflow_o(ov16)
`endif
  );

  bsg_adder_multicycle #(.width_p(16), .chunk_p(1)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .ready_o(rdy1),
    .a_i(a_i), .b_i(b_i), .c_i(c_i), .v_o(vo1), .s_o(s1), .c_o(c1),
    .yumi_i(yumi_i)
`ifdef BSG_ADDER_MULTICYCLE_OVERFLOW_EN
    , .overflow_o(ov1)
`endif
  );

  // yumi may only be raised while every instance presents a result
  always @(negedge clk) begin
    if (reset_n && yumi_i) begin
      assert (vo4 && vo16 && vo1) else begin
        errors++;
        $error("FAIL yumi_protocol obs v_o=%b%b%b exp=111", vo4, vo16, vo1);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  function automatic logic [16:0] ref_sum(input logic [15:0] a, b, input logic c);
    return {1'b0, a} + {1'b0, b} + 17'(c);
  endfunction

  function automatic logic ref_ovf(input logic [15:0] a, b, input logic c);
    int ss;
    ss = int'($signed(a)) + int'($signed(b)) + int'(c);
    return (ss > 32767) || (ss < -32768);
  endfunction

  task automatic do_op(input string tag, input logic [15:0] a, b, input logic c,
                       input bit hold);
    logic [16:0] exp;
    int lat4, lat16, lat1;
    logic [15:0] rs4, rs16, rs1;
    logic rc4, rc16, rc1;
`ifdef BSG_ADDER_MULTICYCLE_OVERFLOW_EN
    logic ro4, ro16, ro1, eo;
    eo = ref_ovf(a, b, c);
`endif
    exp = ref_sum(a, b, c);
    lat4 = 0; lat16 = 0; lat1 = 0;
    rs4 = '0; rs16 = '0; rs1 = '0; rc4 = 0; rc16 = 0; rc1 = 0;
`ifdef BSG_ADDER_MULTICYCLE_OVERFLOW_EN
    ro4 = 0; ro16 = 0; ro1 = 0;
`endif
    chk({tag, "_ready"}, {29'd0, rdy4, rdy16, rdy1}, 32'h7);
    v_i = 1'b1; a_i = a; b_i = b; c_i = c;
    @(negedge clk);
    // operands must not be re-sampled after accept
    v_i = 1'b0; a_i = 16'($urandom); b_i = 16'($urandom); c_i = 1'($urandom);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (vo4 && lat4 == 0) begin
        lat4 = cyc; rs4 = s4; rc4 = c4;
`ifdef BSG_ADDER_MULTICYCLE_OVERFLOW_EN
        ro4 = ov4;
`endif
      end
      if (vo16 && lat16 == 0) begin
        lat16 = cyc; rs16 = s16; rc16 = c16;
`ifdef BSG_ADDER_MULTICYCLE_OVERFLOW_EN
        ro16 = ov16;
`endif
      end
      if (vo1 && lat1 == 0) begin
        lat1 = cyc; rs1 = s1; rc1 = c1;
`ifdef BSG_ADDER_MULTICYCLE_OVERFLOW_EN
        ro1 = ov1;
`endif
      end
      if (lat4 != 0 && lat16 != 0 && lat1 != 0) break;
    end
    chk({tag, "_lat4"}, lat4, 4);
    chk({tag, "_lat16"}, lat16, 1);
    chk({tag, "_lat1"}, lat1, 16);
    chk({tag, "_s4"}, rs4, exp[15:0]);
    chk({tag, "_s16"}, rs16, exp[15:0]);
    chk({tag, "_s1"}, rs1, exp[15:0]);
    chk({tag, "_c"}, {29'd0, rc4, rc16, rc1}, {29'd0, {3{exp[16]}}});
`ifdef BSG_ADDER_MULTICYCLE_OVERFLOW_EN
    chk({tag, "_ovf"}, {29'd0, ro4, ro16, ro1}, {29'd0, {3{eo}}});
`endif
    if (vo4 && vo16 && vo1) begin
      if (hold) begin
        for (int k = 0; k < 10; k++) begin
          v_i = k[0]; a_i = 16'($urandom);
          @(negedge clk);
          chk({tag, "_hold_v"}, {30'd0, vo4, vo1}, 32'h3);
          chk({tag, "_hold_s"}, {s4, s16}, {exp[15:0], exp[15:0]});
          chk({tag, "_hold_rdy"}, {30'd0, rdy4, rdy1}, 32'h0);
        end
        v_i = 1'b0;
      end
      yumi_i = 1'b1;
      @(negedge clk);
      yumi_i = 1'b0;
      chk({tag, "_after_yumi"}, {28'd0, rdy4, vo4, rdy1, vo1}, 32'ha);
    end else begin
      // timeout: recover with a reset so the run continues
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n = 1'b0; v_i = 1'b0; yumi_i = 1'b0; c_i = 1'b0;
    a_i = '0; b_i = '0;
    @(negedge clk); @(negedge clk);
    chk("reset_ctl", {29'd0, rdy4, vo4, c4}, 32'h4);
    chk("reset_s", s4, 0);
    reset_n = 1'b1;
    @(negedge clk);

    do_op("carry8",  16'h00FF, 16'h0001, 1'b0, 1'b0);
    do_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0);
    do_op("cin",     16'h1234, 16'h4321, 1'b1, 1'b1);
    do_op("abcd",    16'hABCD, 16'h1111, 1'b0, 1'b0);
    do_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    do_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0);
    do_op("no_ovf",  16'h0001, 16'hFFFF, 1'b0, 1'b0);

    // reset in the middle of a BUSY phase
    v_i = 1'b1; a_i = 16'hFFFF; b_i = 16'hFFFF; c_i = 1'b0;
    @(negedge clk);
    v_i = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_ctl", {26'd0, rdy4, vo4, c4, rdy16, vo16, rdy1}, 32'h25);
    chk("midrst_s", {s4, s16}, 0);
`ifdef BSG_ADDER_MULTICYCLE_OVERFLOW_EN
    chk("midrst_ovf", {31'd0, ov4}, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_op("post_rst", 16'h0003, 16'h0004, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++)
      do_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), i == 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
